// File: rtl/bit_scan_32.sv
// Set-bit scanner: accepts a 32-bit word, emits set-bit positions LSB first, then pulses done with the popcount.
// idx first valid 1 cycle after accept; idx_ready low holds idx/pending; in_ready only while idle.
module bit_scan_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] data,
  output logic        idx_valid,
  input  logic        idx_ready,
  output logic [4:0]  idx,
  output logic        idx_last,
  output logic        zero,
  output logic        done,
  output logic [5:0]  count
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  state_t      state_q, state_d;
  logic [31:0] pending_q, pending_d;
  logic [5:0]  run_cnt_q, run_cnt_d;
  logic [5:0]  count_q, count_d;

  logic [4:0]  lsb_idx;
  logic [31:0] pending_clr;
  logic        one_left;

  always_comb begin
    lsb_idx = 5'd0;
    for (int i = 31; i >= 0; i--) begin
      if (pending_q[i]) lsb_idx = 5'(i);
    end
  end

  // Clearing the lowest set bit also tells us whether it was the only one.
  assign pending_clr = pending_q & (pending_q - 32'd1);
  assign one_left    = (pending_q != 32'd0) && (pending_clr == 32'd0);

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    run_cnt_d = run_cnt_q;
    count_d   = count_q;
    in_ready  = 1'b0;
    idx_valid = 1'b0;
    idx       = 5'd0;
    idx_last  = 1'b0;
    zero      = 1'b0;
    done      = 1'b0;
    count     = count_q;
    unique case (state_q)
      IDLE: begin
        in_ready = rst_n;
        if (in_valid && rst_n) begin
          pending_d = data;
          run_cnt_d = 6'd0;
          state_d   = (data == 32'd0) ? FIN : SCAN;
        end
      end
      SCAN: begin
        idx_valid = 1'b1;
        idx       = lsb_idx;
        idx_last  = one_left;
        if (idx_ready) begin
          pending_d = pending_clr;
          run_cnt_d = run_cnt_q + 6'd1;
          if (one_left) state_d = FIN;
        end
      end
      FIN: begin
        done    = 1'b1;
        zero    = (run_cnt_q == 6'd0);
        count   = run_cnt_q;
        count_d = run_cnt_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= 32'd0;
      run_cnt_q <= 6'd0;
      count_q   <= 6'd0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      run_cnt_q <= run_cnt_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: doc/bit_scan_32.md
BIT_SCAN_32 -- requirements
Module: bit_scan_32

Interface
REQ-001 SHALL have a single clock and an asynchronous, active-low reset; no other clock or reset inputs.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a 32-bit word is offered on data.
REQ-005 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-006 SHALL have port data, input, 32 bits: word to scan, sampled only on accept.
REQ-007 SHALL have port idx_valid, output, 1 bit: idx carries the position of a set bit.
REQ-008 SHALL have port idx_ready, input, 1 bit: consumer takes idx this cycle.
REQ-009 SHALL have port idx, output, 5 bits: bit position 0..31.
REQ-010 SHALL have port idx_last, output, 1 bit: the current idx is the final set bit of the word.
REQ-011 SHALL have port zero, output, 1 bit: one-cycle pulse when an accepted word is all zeros.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse when a word is fully processed.
REQ-013 SHALL have port count, output, 6 bits: number of set bits in the last completed word (0..32).

Function
REQ-014 SHALL implement the states IDLE, SCAN and FIN.
REQ-015 SHALL assert in_ready only in IDLE; accept occurs on in_valid && in_ready.
REQ-016 SHALL, on accept, capture data into an internal pending register and clear the running count.
REQ-017 SHALL, on accept of a nonzero word, go to SCAN; idx_valid SHALL first rise on the cycle after accept (latency 1).
REQ-018 SHALL, on accept of data == 0, go to FIN, and SHALL never assert idx_valid for that word.
REQ-019 SHALL, in SCAN, drive idx_valid = 1 and idx = position of the lowest set bit of pending (LSB first).
REQ-020 SHALL drive idx_last = 1 exactly when pending has one bit set.
REQ-021 SHALL, on idx_valid && idx_ready, clear that bit in pending and increment the running count.
REQ-022 SHALL, when idx_valid && !idx_ready, hold idx, idx_last and pending unchanged.
REQ-023 SHALL sustain one index per cycle when idx_ready is held high.
REQ-024 SHALL, on the handshake with idx_last = 1, go to FIN.
REQ-025 SHALL, in FIN, assert done for exactly one cycle, latch the running count into count, and assert zero in the same cycle if the word was zero; the next state SHALL be IDLE.
REQ-026 SHALL hold count stable from the FIN cycle until the next FIN.
REQ-027 SHALL ignore data and in_valid in SCAN and FIN, and SHALL drop nothing when in_valid is held high.
REQ-028 SHALL produce count = 32 for data = 0xFFFFFFFF; the count width SHALL NOT wrap.
REQ-029 SHALL drive idx = 0 and idx_last = 0 whenever idx_valid = 0.

Reset
REQ-030 SHALL, on rst_n low at any time including mid-SCAN, immediately enter IDLE and abandon the word in progress.
REQ-031 SHALL, during reset, drive in_ready = 0, idx_valid = 0, idx = 0, idx_last = 0, zero = 0, done = 0, count = 0, and pending = 0.
REQ-032 SHALL assert in_ready in the first clock cycle after rst_n deasserts.

Verification
REQ-033 SHALL pass: data = 0x80000005, idx_ready = 1 -> idx 0, 2, 31 on three consecutive cycles starting one cycle after accept; idx_last only with 31; done next cycle; count = 3.
REQ-034 SHALL pass: data = 0x00000000 -> no idx_valid; zero and done high together one cycle after accept; count = 0; in_ready high the following cycle.
REQ-035 SHALL pass: data = 0xFFFFFFFF, idx_ready = 1 -> 32 indices 0..31 on consecutive cycles; count = 32.
REQ-036 SHALL pass: data = 0x00000110, idx_ready low for 3 cycles -> idx = 4 is held stable for 3 cycles, then 4 and 8 are delivered; count = 2.
REQ-037 SHALL pass: rst_n pulsed low while idx = 2 of 0x0000000C is pending -> all outputs are 0 at once; in_ready = 1 after release; the next word 0x1 yields idx 0 and count = 1.
REQ-038 SHALL pass: in_valid held high with back-to-back words 0x3 and 0x4 -> the second word is accepted only after the first word's done; indices are 0, 1, then 2.
